// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic processing element.
package systolic_pkg;

   typedef enum logic [1:0] {
      WS       = 2'd0,
      OS_ACC   = 2'd1,
      OS_DRAIN = 2'd2
   } pe_state_t;

   typedef enum logic {
      MODE_WS = 1'b0,
      MODE_OS = 1'b1
   } pe_mode_t;

   // Takes the top two bits of a sum that is one bit wider than its target.
   // Returns {positive overflow, negative overflow}; works for any width.
   function automatic logic [1:0] pe_sat_dir(input logic i_ext, input logic i_msb);
      return {~i_ext & i_msb, i_ext & ~i_msb};
   endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply-add with reduction to ACC_WIDTH.
// Saturates when PE_SAT_EN is defined, otherwise wraps; o_ovf flags either case.
module pe_mac
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
)(
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [ACC_WIDTH-1:0]  i_addend,
   output logic [ACC_WIDTH-1:0]  o_sum,
   output logic                  o_ovf
);
   localparam int PW = 2 * DATA_WIDTH;

   logic signed [PW-1:0] w_a_ext;
   logic signed [PW-1:0] w_b_ext;
   logic signed [PW-1:0] w_prod;
   logic [ACC_WIDTH:0]   w_sum;
   logic [1:0]           w_dir;

   // Operands widened first so the low PW bits hold the exact signed product.
   assign w_a_ext = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
   assign w_b_ext = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
   assign w_prod  = w_a_ext * w_b_ext;
   assign w_sum   = {{(ACC_WIDTH+1-PW){w_prod[PW-1]}}, w_prod}
                  + {i_addend[ACC_WIDTH-1], i_addend};
   assign w_dir   = pe_sat_dir(w_sum[ACC_WIDTH], w_sum[ACC_WIDTH-1]);
   assign o_ovf   = |w_dir;

`ifdef PE_SAT_EN
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   always_comb begin
      o_sum = w_sum[ACC_WIDTH-1:0];
      if (w_dir[1]) begin
         o_sum = ACC_MAX;
      end else if (w_dir[0]) begin
         o_sum = ACC_MIN;
      end
   end
`else
   assign o_sum = w_sum[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/systolic_pe_v2.sv
// Systolic MAC cell with run-time WS/OS modes, double-buffered weights and OS drain chain.
// Build option: define PE_SAT_EN for saturating arithmetic (default wraps).
module systolic_pe_v2
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ctrl_mode_i,
   input  logic                  ctrl_load_i,
   input  logic                  ctrl_swap_i,
   input  logic                  ctrl_clear_i,
   input  logic                  ctrl_drain_i,
   input  logic                  west_valid_i,
   input  logic [DATA_WIDTH-1:0] west_data_i,
   input  logic                  north_valid_i,
   input  logic [ACC_WIDTH-1:0]  north_data_i,
   output logic                  east_valid_o,
   output logic [DATA_WIDTH-1:0] east_data_o,
   output logic                  south_valid_o,
   output logic [ACC_WIDTH-1:0]  south_data_o,
   output logic                  overflow_o
);
   pe_state_t             r_state;
   pe_state_t             w_state_next;
   logic [DATA_WIDTH-1:0] r_shadow;
   logic [DATA_WIDTH-1:0] r_active;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic                  r_ovf;
   logic                  r_east_valid;
   logic [DATA_WIDTH-1:0] r_east_data;
   logic                  r_south_valid;
   logic [ACC_WIDTH-1:0]  r_south_data;

   pe_mode_t              w_mode;
   logic                  w_idle;
   logic                  w_both;
   logic [DATA_WIDTH-1:0] w_mac_a;
   logic [ACC_WIDTH-1:0]  w_mac_addend;
   logic [ACC_WIDTH-1:0]  w_mac_sum;
   logic                  w_mac_ovf;
   logic [ACC_WIDTH-1:0]  w_acc_base;
   logic [ACC_WIDTH-1:0]  w_north_sext;
   logic [ACC_WIDTH-1:0]  w_acc_next;
   logic                  w_ovf_event;
   logic                  w_south_valid_next;
   logic [ACC_WIDTH-1:0]  w_south_data_next;

   assign w_mode       = pe_mode_t'(ctrl_mode_i);
   assign w_idle       = ~west_valid_i & ~north_valid_i;
   assign w_both       = west_valid_i & north_valid_i;
   assign w_acc_base   = ctrl_clear_i ? '0 : r_acc;
   assign w_north_sext = {{(ACC_WIDTH-DATA_WIDTH){north_data_i[DATA_WIDTH-1]}},
                          north_data_i[DATA_WIDTH-1:0]};

   // One multiplier serves both modes; only the operand routing differs.
   assign w_mac_a      = (r_state == WS) ? r_active : north_data_i[DATA_WIDTH-1:0];
   assign w_mac_addend = (r_state == WS) ? north_data_i : w_acc_base;

   pe_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .i_a      (w_mac_a),
      .i_b      (west_data_i),
      .i_addend (w_mac_addend),
      .o_sum    (w_mac_sum),
      .o_ovf    (w_mac_ovf)
   );

   // Mode switches wait for a bubble so no operand straddles two modes.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         WS: begin
            if (w_mode == MODE_OS && w_idle) w_state_next = OS_ACC;
         end
         OS_ACC, OS_DRAIN: begin
            if (w_mode == MODE_WS && w_idle) w_state_next = WS;
            else if (ctrl_drain_i)           w_state_next = OS_DRAIN;
            else                             w_state_next = OS_ACC;
         end
         default: w_state_next = WS;
      endcase
   end

   always_comb begin
      w_acc_next         = w_acc_base;
      w_ovf_event        = 1'b0;
      w_south_valid_next = 1'b0;
      w_south_data_next  = r_south_data;
      case (r_state)
         WS: begin
            if (w_both) begin
               w_south_data_next  = w_mac_sum;
               w_south_valid_next = 1'b1;
               w_ovf_event        = w_mac_ovf;
            end
         end
         OS_ACC: begin
            if (ctrl_drain_i) begin
               w_south_data_next  = r_acc;
               w_south_valid_next = 1'b1;
            end else begin
               w_south_valid_next = north_valid_i;
               if (north_valid_i) w_south_data_next = w_north_sext;
               if (w_both) begin
                  w_acc_next  = w_mac_sum;
                  w_ovf_event = w_mac_ovf;
               end
            end
         end
         OS_DRAIN: begin
            w_south_valid_next = north_valid_i;
            w_south_data_next  = north_data_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= WS;
         r_shadow      <= '0;
         r_active      <= '0;
         r_acc         <= '0;
         r_ovf         <= 1'b0;
         r_east_valid  <= 1'b0;
         r_east_data   <= '0;
         r_south_valid <= 1'b0;
         r_south_data  <= '0;
      end else begin
         r_state       <= w_state_next;
         r_acc         <= w_acc_next;
         r_ovf         <= (ctrl_clear_i ? 1'b0 : r_ovf) | w_ovf_event;
         r_east_valid  <= west_valid_i;
         r_east_data   <= west_data_i;
         r_south_valid <= w_south_valid_next;
         r_south_data  <= w_south_data_next;
         if (ctrl_load_i) r_shadow <= north_data_i[DATA_WIDTH-1:0];
         if (ctrl_swap_i) r_active <= r_shadow;
      end
   end

   assign east_valid_o  = r_east_valid;
   assign east_data_o   = r_east_data;
   assign south_valid_o = r_south_valid;
   assign south_data_o  = r_south_data;
   assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_systolic_pe_v2.sv
// Self-checking bench for systolic_pe_v2: directed literal checks plus randomized
// traffic compared every cycle against an integer-arithmetic reference model.
module tb_systolic_pe_v2;
   localparam int DW = 8;
   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mode = 1'b0, load = 1'b0, swap = 1'b0, clear = 1'b0, drain = 1'b0;
   logic          wv = 1'b0, nv = 1'b0;
   logic [DW-1:0] wd = '0;
   logic [AW-1:0] nd = '0;
   logic          ev, sv, ovf;
   logic [DW-1:0] ed;
   logic [AW-1:0] sd;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   systolic_pe_v2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ctrl_mode_i   (mode),
      .ctrl_load_i   (load),
      .ctrl_swap_i   (swap),
      .ctrl_clear_i  (clear),
      .ctrl_drain_i  (drain),
      .west_valid_i  (wv),
      .west_data_i   (wd),
      .north_valid_i (nv),
      .north_data_i  (nd),
      .east_valid_o  (ev),
      .east_data_o   (ed),
      .south_valid_o (sv),
      .south_data_o  (sd),
      .overflow_o    (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reduce an exact integer sum into the signed AW-bit range.
   function automatic longint reduce(input longint s, output bit o);
      longint mx, mn, span, r;
      span = longint'(1) <<< AW;
      mx   = (longint'(1) <<< (AW - 1)) - 1;
      mn   = -(longint'(1) <<< (AW - 1));
      o    = (s > mx) || (s < mn);
      r    = s;
`ifdef PE_SAT_EN
      if (s > mx) r = mx;
      if (s < mn) r = mn;
`else
      while (r > mx) r = r - span;
      while (r < mn) r = r + span;
`endif
      return r;
   endfunction

   // Reference model: OS/WS mode flag, "already emitted acc" flag, plain integers.
   longint m_acc, m_active, m_shadow, e_sd;
   bit     m_os, m_drn, m_ovf, e_sv, e_ev;
   logic [DW-1:0] e_ed;

   initial begin
      longint wsig, nsig, nlo, acc_base, s;
      bit both, idle, o, ev_ovf, ovf_base;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_acc = 0; m_active = 0; m_shadow = 0; e_sd = 0;
            m_os = 0; m_drn = 0; m_ovf = 0; e_sv = 0; e_ev = 0; e_ed = '0;
         end else begin
            both     = wv && nv;
            idle     = !wv && !nv;
            wsig     = longint'($signed(wd));
            nsig     = longint'($signed(nd));
            nlo      = longint'($signed(nd[DW-1:0]));
            acc_base = clear ? 0 : m_acc;
            ovf_base = clear ? 1'b0 : m_ovf;
            ev_ovf   = 1'b0;
            e_ev     = wv;
            e_ed     = wd;
            if (!m_os) begin
               if (both) begin
                  s = reduce(nsig + m_active * wsig, o);
                  e_sd = s; e_sv = 1'b1; ev_ovf = o;
               end else begin
                  e_sv = 1'b0;
               end
            end else if (m_drn) begin
               e_sv = nv; e_sd = nsig;
            end else if (drain) begin
               e_sv = 1'b1; e_sd = m_acc;
            end else begin
               e_sv = nv;
               if (nv) e_sd = nlo;
               if (both) acc_base = reduce(acc_base + nlo * wsig, ev_ovf);
            end
            m_acc = acc_base;
            m_ovf = ovf_base | ev_ovf;
            if (swap) m_active = m_shadow;
            if (load) m_shadow = nlo;
            if (m_os) m_drn = drain;
            if (idle && (mode != m_os)) begin
               m_os = mode; m_drn = 1'b0;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && chk_en) begin
            chk("south_valid", sv, e_sv);
            chk("south_data", longint'($signed(sd)), e_sd);
            chk("east_valid", ev, e_ev);
            chk("east_data", ed, e_ed);
            chk("overflow", ovf, m_ovf);
         end
      end
   end

   task automatic drv(input bit i_wv, input logic [DW-1:0] i_wd, input bit i_nv,
                      input logic [AW-1:0] i_nd, input bit i_ld, input bit i_sw,
                      input bit i_cl, input bit i_dr);
      wv = i_wv; wd = i_wd; nv = i_nv; nd = i_nd;
      load = i_ld; swap = i_sw; clear = i_cl; drain = i_dr;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      @(negedge clk);
      if (tag != "") $display("txn %-14s south_v=%0d south_d=%0d ovf=%0d", tag, sv, $signed(sd), ovf);
   endtask

   initial begin
      int dr_cnt;
      bit r_wv, r_nv, r_ld, r_sw, r_cl, r_dr;
      dr_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_south_valid", sv, 0);
      chk("rst_south_data", sd, 0);
      chk("rst_east_valid", ev, 0);
      chk("rst_east_data", ed, 0);
      chk("rst_overflow", ovf, 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // WS with double-buffered weights
      drv(0, 0, 0, 24'd3, 1, 0, 0, 0);   tick("load3");
      drv(0, 0, 0, 0, 0, 1, 0, 0);       tick("swap");
      drv(1, 8'd5, 1, 24'd100, 0, 0, 0, 0); tick("ws_mac");
      chk("ws_sum", $signed(sd), 115);
      chk("ws_valid", sv, 1);
      chk("ws_ovf", ovf, 0);
      chk("ws_east", ed, 5);
      drv(0, 0, 0, 24'd6, 1, 0, 0, 0);   tick("load6");
      drv(1, 8'd5, 1, 24'd100, 0, 0, 0, 0); tick("ws_old_w");
      chk("db_old_weight", $signed(sd), 115);
      drv(0, 0, 0, 0, 0, 1, 0, 0);       tick("swap");
      drv(1, 8'd5, 1, 24'd100, 0, 0, 0, 0); tick("ws_new_w");
      chk("db_new_weight", $signed(sd), 130);
      drv(0, 0, 0, 24'd9, 1, 1, 0, 0);   tick("load9_swap");
      drv(1, 8'd5, 1, 24'd100, 0, 0, 0, 0); tick("ws_ls");
      chk("ls_old_shadow", $signed(sd), 130);
      drv(0, 0, 0, 0, 0, 1, 0, 0);       tick("swap");
      drv(1, 8'd5, 1, 24'd100, 0, 0, 0, 0); tick("ws_ls2");
      chk("ls_new_shadow", $signed(sd), 145);

      // OS accumulate and drain
      mode = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("to_os");
      drv(0, 0, 0, 0, 0, 0, 1, 0);       tick("clear");
      drv(1, 8'd3, 1, 24'd2, 0, 0, 0, 0); tick("os_2x3");
      chk("os_fwd", $signed(sd), 2);
      drv(1, 8'd5, 1, 24'hFFFFFC, 0, 0, 0, 0); tick("os_m4x5");
      chk("os_fwd_neg", $signed(sd), -4);
      drv(1, 8'd7, 1, 24'd7, 0, 0, 0, 0); tick("os_7x7");
      drv(0, 0, 0, 0, 0, 0, 0, 1);       tick("drain");
      chk("drain_acc", $signed(sd), 35);
      chk("drain_valid", sv, 1);
      drv(0, 0, 1, 24'd9, 0, 0, 0, 1);   tick("drain_pass");
      chk("drain_pass", $signed(sd), 9);
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("idle");

      // Clear together with an accumulate
      drv(0, 0, 0, 0, 0, 0, 1, 0);       tick("clear");
      drv(1, 8'd10, 1, 24'd5, 0, 0, 0, 0); tick("os_5x10");
      drv(1, 8'd4, 1, 24'd4, 0, 0, 1, 0); tick("clr_4x4");
      drv(0, 0, 0, 0, 0, 0, 0, 1);       tick("drain");
      chk("clear_acc", $signed(sd), 16);
      chk("clear_ovf", ovf, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("idle");

      // Overflow: build 8388600 = 511*16384 + 16129 + 247
      drv(0, 0, 0, 0, 0, 0, 1, 0);       tick("clear");
      for (int i = 0; i < 511; i++) begin
         drv(1, 8'h80, 1, 24'h000080, 0, 0, 0, 0); tick("");
      end
      drv(1, 8'd127, 1, 24'd127, 0, 0, 0, 0); tick("os_127x127");
      drv(1, 8'd19, 1, 24'd13, 0, 0, 0, 0);   tick("os_13x19");
      drv(0, 0, 0, 0, 0, 0, 0, 1);       tick("drain");
      chk("pre_ovf_acc", $signed(sd), 8388600);
      chk("pre_ovf_flag", ovf, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("idle");
      drv(1, 8'd127, 1, 24'd127, 0, 0, 0, 0); tick("os_ovf");
      chk("ovf_set", ovf, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 1);       tick("drain");
`ifdef PE_SAT_EN
      chk("ovf_acc", $signed(sd), 8388607);
`else
      chk("ovf_acc", $signed(sd), -8372487);
`endif
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("idle");
      chk("ovf_sticky", ovf, 1);
      drv(0, 0, 0, 0, 0, 0, 1, 0);       tick("clear");
      chk("ovf_cleared", ovf, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 2) mode = ~mode;
         r_wv = ($urandom_range(0, 9) < 7);
         r_nv = ($urandom_range(0, 9) < 7);
         r_ld = ($urandom_range(0, 9) == 0);
         r_sw = ($urandom_range(0, 9) == 0);
         r_cl = ($urandom_range(0, 49) == 0);
         if (dr_cnt > 0) begin
            r_dr = 1'b1;
            dr_cnt--;
         end else begin
            r_dr = 1'b0;
            if ($urandom_range(0, 29) == 0) dr_cnt = $urandom_range(1, 4);
         end
         drv(r_wv, 8'($urandom), r_nv, 24'($urandom), r_ld, r_sw, r_cl, r_dr);
         tick("");
      end

      // Asynchronous reset in the middle of a drain
      mode = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("idle");
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("idle");
      drv(1, 8'd2, 1, 24'd3, 0, 0, 0, 0); tick("os_3x2");
      drv(0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_south_valid", sv, 0);
      chk("arst_south_data", sd, 0);
      chk("arst_east_valid", ev, 0);
      chk("arst_overflow", ovf, 0);
      @(negedge clk);
      mode = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("post_rst_idle");
         chk("post_rst_no_valid", sv, 0);
      end
      drv(1, 8'd5, 1, 24'd300, 0, 0, 0, 0); tick("post_rst_ws");
      chk("post_rst_ws_sum", $signed(sd), 300);
      drv(0, 0, 0, 0, 0, 0, 0, 0);       tick("idle");

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
